dmem_lsu: RTL and testbench

Load/store unit between the core's memory stage and a realistic, multi-cycle data memory with valid/ready handshakes, replacing the combinational dmem port. Accepts one load or store per transaction from the core, checks alignment, and produces word-aligned address, byte mask and lane-shifted write data. Returns sign/zero-extended load data or a trap flag. Stalls the core via `o_req_ready` until each transaction completes; at most one transaction is outstanding.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_align.sv | 66 ++++++
 rtl/dmem_lsu.sv | 205 ++++++++++++++++++++
 tb/tb_dmem_lsu.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the data-memory load/store unit:
//   - FSM state encoding (IDLE, REQ, WAIT, RESP)
//   - access-size encodings (SZ_B, SZ_H, SZ_W; 2'b11 is illegal)
//   - default bus-timeout limit used by dmem_lsu when LSU_TIMEOUT_EN is set
//   - lsu_req_t, the request fields captured at the core handshake
// -----------------------------------------------------------------------------
package lsu_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Access size encoding (i_req_size)
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Cycles allowed in REQ+WAIT before a bus-timeout trap
    localparam int WAIT_LIMIT_DEF = 255;

    // Request captured at the core handshake and held for the transaction
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        is_unsigned;
        logic        is_store;
    } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the load/store unit.
//   addr_lo     in  2   byte offset within the word (addr[1:0])
//   size        in  2   SZ_B / SZ_H / SZ_W; 2'b11 is illegal
//   wdata       in  32  store data, value in the low bits
//   rdata       in  32  load word from memory
//   is_unsigned in  1   zero-extend instead of sign-extend
//   mask        out 4   byte enables for the access
//   wdata_sh    out 32  store data moved onto its byte lanes
//   misaligned  out 1   access crosses its natural boundary or size is illegal
//   rdata_ext   out 32  load data moved to bit 0 and extended to 32 bits
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        is_unsigned,
    output logic [3:0]  mask,
    output logic [31:0] wdata_sh,
    output logic        misaligned,
    output logic [31:0] rdata_ext
);

    logic [4:0]  shamt;
    logic [31:0] rdata_sh;

    assign shamt    = {addr_lo, 3'b000};
    assign wdata_sh = wdata << shamt;
    assign rdata_sh = rdata >> shamt;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        mask       = 4'b0000;
        misaligned = 1'b1;
        rdata_ext  = 32'h0;
        case (size)
            SZ_B: begin
                mask       = 4'b0001 << addr_lo;
                misaligned = 1'b0;
                rdata_ext  = {{24{~is_unsigned & rdata_sh[7]}}, rdata_sh[7:0]};
            end
            SZ_H: begin
                mask       = addr_lo[1] ? 4'b1100 : 4'b0011;
                misaligned = addr_lo[0];
                rdata_ext  = {{16{~is_unsigned & rdata_sh[15]}}, rdata_sh[15:0]};
            end
            SZ_W: begin
                mask       = 4'b1111;
                misaligned = |addr_lo;
                rdata_ext  = rdata_sh;
            end
            default: begin
                // size 2'b11: illegal, flagged through misaligned
                mask       = 4'b0000;
                misaligned = 1'b1;
                rdata_ext  = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu
// Load/store unit between the core memory stage and a multi-cycle data memory
// with valid/ready handshakes. One transaction outstanding at a time; the core
// is stalled through o_req_ready until the response pulse.
//
// Build option: define LSU_TIMEOUT_EN to add a bus-timeout counter. After
// WAIT_LIMIT cycles in REQ+WAIT the transaction ends with a trap response.
// Without it REQ and WAIT wait indefinitely.
//
// Ports
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_req_valid/o_req_ready   core request handshake (ready only in IDLE)
//   i_req_load/i_req_store    operation select, exactly one high
//   i_req_addr[31:0]      byte address
//   i_req_wdata[31:0]     store data in the low bits
//   i_req_size[1:0]       00 byte, 01 half, 10 word, 11 illegal
//   i_req_unsigned        zero-extend loads
//   o_resp_valid          one-cycle completion pulse
//   o_resp_rdata[31:0]    extended load data; 0 for stores and traps
//   o_resp_trap           misaligned / illegal / timeout
//   o_mem_valid/i_mem_ready   memory request handshake
//   o_mem_wen/o_mem_ren   write / read strobes
//   o_mem_addr[31:0]      word-aligned address
//   o_mem_wdata[31:0]     lane-shifted store data
//   o_mem_mask[3:0]       byte enables
//   i_mem_rvalid          load data strobe (honoured only in WAIT)
//   i_mem_rdata[31:0]     load data word
// -----------------------------------------------------------------------------
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_load,
    input  logic        i_req_store,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_trap,
    output logic        o_mem_valid,
    input  logic        i_mem_ready,
    output logic        o_mem_wen,
    output logic        o_mem_ren,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    logic [1:0]  state;
    lsu_req_t    req_q;
    logic        trap_q;
    logic [31:0] rdata_q;

    logic        handshake;
    logic        illegal;
    logic        in_idle;
    logic        in_req;
    logic        in_resp;

    logic [1:0]  al_addr_lo;
    logic [1:0]  al_size;
    logic [31:0] al_wdata;
    logic        al_unsigned;
    logic [3:0]  al_mask;
    logic [31:0] al_wdata_sh;
    logic        al_misaligned;
    logic [31:0] al_rdata_ext;

    assign in_idle = (state == ST_IDLE);
    assign in_req  = (state == ST_REQ);
    assign in_resp = (state == ST_RESP);

    assign o_req_ready = in_idle & ~i_rst;
    assign handshake   = i_req_valid & o_req_ready;

    // One aligner serves both phases: in IDLE it checks the incoming request,
    // afterwards it works on the captured request so memory-side outputs stay
    // stable regardless of what the core drives meanwhile.
    assign al_addr_lo  = in_idle ? i_req_addr[1:0] : req_q.addr[1:0];
    assign al_size     = in_idle ? i_req_size      : req_q.size;
    assign al_wdata    = in_idle ? i_req_wdata     : req_q.wdata;
    assign al_unsigned = in_idle ? i_req_unsigned  : req_q.is_unsigned;

    lsu_align u_align (
        .addr_lo     (al_addr_lo),
        .size        (al_size),
        .wdata       (al_wdata),
        .rdata       (i_mem_rdata),
        .is_unsigned (al_unsigned),
        .mask        (al_mask),
        .wdata_sh    (al_wdata_sh),
        .misaligned  (al_misaligned),
        .rdata_ext   (al_rdata_ext)
    );

    // Load and store both high, or neither, is as illegal as a bad size.
    assign illegal = al_misaligned | (i_req_load == i_req_store);

`ifdef LSU_TIMEOUT_EN
    // Wide enough to hold WAIT_LIMIT: a load accepted on the last allowed REQ
    // cycle moves on to WAIT with the count already at the limit.
    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;

    assign timed_out = (wait_cnt >= CNT_W'(WAIT_LIMIT - 1));

    // Zero outside REQ/WAIT, so it is always clear on entry to REQ.
    always_ff @(posedge i_clk) begin
        if (i_rst || !(state == ST_REQ || state == ST_WAIT)) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    // WAIT_LIMIT stays on the interface so both builds share one instantiation.
    logic unused_wait_limit;
    assign unused_wait_limit = (WAIT_LIMIT != 0);
`endif

    // NOTE: state and datapath registers use non-blocking assignments so every
    // register samples the pre-edge values; blocking here would create ordering
    // races between registers. Datapath registers are reset as well so the
    // gated outputs and the response fields read 0 straight out of reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            req_q   <= '0;
            trap_q  <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        req_q.addr        <= i_req_addr;
                        req_q.wdata       <= i_req_wdata;
                        req_q.size        <= i_req_size;
                        req_q.is_unsigned <= i_req_unsigned;
                        req_q.is_store    <= i_req_store;
                        rdata_q           <= 32'h0;
                        trap_q            <= illegal;
                        state             <= illegal ? ST_RESP : ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A completed memory handshake beats a same-cycle timeout:
                    // the memory has already acted on the request.
                    if (i_mem_ready) begin
                        state <= req_q.is_store ? ST_RESP : ST_WAIT;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (timed_out) begin
                        trap_q <= 1'b1;
                        state  <= ST_RESP;
                    end
`endif
                end
                ST_WAIT: begin
                    if (i_mem_rvalid) begin
                        rdata_q <= al_rdata_ext;
                        state   <= ST_RESP;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (timed_out) begin
                        trap_q <= 1'b1;
                        state  <= ST_RESP;
                    end
`endif
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory side: driven only while a request is presented.
    assign o_mem_valid = in_req;
    assign o_mem_wen   = in_req &  req_q.is_store;
    assign o_mem_ren   = in_req & ~req_q.is_store;
    assign o_mem_addr  = in_req ? {req_q.addr[31:2], 2'b00} : 32'h0;
    assign o_mem_mask  = in_req ? al_mask : 4'b0000;
    assign o_mem_wdata = in_req ? al_wdata_sh : 32'h0;

    // Core response: fields are zero outside the RESP pulse.
    assign o_resp_valid = in_resp;
    assign o_resp_trap  = in_resp & trap_q;
    assign o_resp_rdata = in_resp ? rdata_q : 32'h0;

endmodule

// File: tb/tb_dmem_lsu.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu
// Directed bench for dmem_lsu. Expected responses (data, trap, completion
// cycle) are queued when a request is driven and popped when o_resp_valid
// appears. Define LSU_TIMEOUT_EN for both RTL and bench to cover the timeout.
// -----------------------------------------------------------------------------
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic        req_store;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_trap;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_wen;
    logic        mem_ren;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    dmem_lsu #(.WAIT_LIMIT(4)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_load     (req_load),
        .i_req_store    (req_store),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .i_req_size     (req_size),
        .i_req_unsigned (req_unsigned),
        .o_resp_valid   (resp_valid),
        .o_resp_rdata   (resp_rdata),
        .o_resp_trap    (resp_trap),
        .o_mem_valid    (mem_valid),
        .i_mem_ready    (mem_ready),
        .o_mem_wen      (mem_wen),
        .o_mem_ren      (mem_ren),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .o_mem_mask     (mem_mask),
        .i_mem_rvalid   (mem_rvalid),
        .i_mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        trap;
        int          at_cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   last_hs = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for o_resp_valid, pop the expectation and compare.
    task automatic expect_resp(input string tag);
        bit   seen;
        exp_t e;
        seen = 1'b0;
        for (int k = 0; k < 16 && !seen; k++) begin
            if (resp_valid === 1'b1) seen = 1'b1;
            else step();
        end
        check({tag, ".resp_seen"}, 32'(seen), 32'd1);
        if (sb.size() == 0) begin
            check({tag, ".sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            if (seen) begin
                check({tag, ".resp_cycle"}, 32'(cyc), 32'(e.at_cyc));
                check({tag, ".rdata"}, resp_rdata, e.rdata);
                check({tag, ".trap"}, 32'(resp_trap), 32'(e.trap));
                check({tag, ".memv_in_resp"}, 32'(mem_valid), 32'd0);
                step();
                check({tag, ".resp_one_cycle"}, 32'(resp_valid), 32'd0);
                check({tag, ".ready_after"}, 32'(req_ready), 32'd1);
            end
        end
    endtask

    // Full transaction: drive request, serve the memory with the given delays,
    // and check the memory-side request every REQ cycle.
    task automatic txn(input string tag, input logic ld, input logic st,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns,
                       input int rdy_dly, input int rv_dly, input logic [31:0] mem_word,
                       input logic [31:0] exp_rdata, input logic exp_trap,
                       input logic [3:0] exp_mask, input logic [31:0] exp_wdata);
        int   c0;
        int   lat;
        exp_t e;
        check({tag, ".ready_before"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_load     = ld;
        req_store    = st;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        step();
        c0      = cyc;
        last_hs = c0;
        // Scramble the request bus: the DUT must work from captured values.
        req_valid    = 1'b0;
        req_load     = 1'b0;
        req_store    = 1'b0;
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_size     = 2'($urandom_range(0, 3));
        req_unsigned = 1'($urandom_range(0, 1));
        if (exp_trap) lat = 0;
        else if (st) lat = 1 + rdy_dly;
        else lat = 2 + rdy_dly + rv_dly;
        e.rdata  = exp_rdata;
        e.trap   = exp_trap;
        e.at_cyc = c0 + lat;
        sb.push_back(e);
        check({tag, ".ready_busy"}, 32'(req_ready), 32'd0);
        if (!exp_trap) begin
            for (int k = 0; k <= rdy_dly; k++) begin
                check({tag, ".mem_valid"}, 32'(mem_valid), 32'd1);
                check({tag, ".mem_addr"}, mem_addr, {addr[31:2], 2'b00});
                check({tag, ".mem_mask"}, 32'(mem_mask), 32'(exp_mask));
                check({tag, ".mem_wen"}, 32'(mem_wen), 32'(st));
                check({tag, ".mem_ren"}, 32'(mem_ren), 32'(ld));
                if (st) check({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
                mem_ready  = (k == rdy_dly);
                // Stray rvalid while still in REQ must be ignored.
                mem_rvalid = (k != rdy_dly);
                mem_rdata  = 32'hBAD0_0000 | 32'(k);
                step();
            end
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            if (ld) begin
                for (int k = 0; k <= rv_dly; k++) begin
                    check({tag, ".memv_in_wait"}, 32'(mem_valid), 32'd0);
                    mem_rvalid = (k == rv_dly);
                    mem_rdata  = (k == rv_dly) ? mem_word : 32'h0BAD_BAD0;
                    step();
                end
                mem_rvalid = 1'b0;
            end
        end else begin
            check({tag, ".no_mem_access"}, 32'(mem_valid), 32'd0);
        end
        expect_resp(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h1;
        int c0;
        int memv_cycles;
        bit any_resp;

        rst = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_size = 2'b00; req_unsigned = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

        // Reset state
        step();
        step();
        check("rst.ready", 32'(req_ready), 32'd0);
        check("rst.mem_valid", 32'(mem_valid), 32'd0);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.mem_addr", mem_addr, 32'h0);
        check("rst.mem_mask", 32'(mem_mask), 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'h0);
        rst = 1'b0;
        #1;
        check("rst.ready_after", 32'(req_ready), 32'd1);

        // Stores, back to back
        txn("sw", 0, 1, 32'h0000_1000, 32'hDEAD_BEEF, 2'b10, 0, 0, 0, 32'h0,
            32'h0, 0, 4'b1111, 32'hDEAD_BEEF);
        h1 = last_hs;
        txn("sb", 0, 1, 32'h0000_2003, 32'h0000_00A5, 2'b00, 0, 0, 0, 32'h0,
            32'h0, 0, 4'b1000, 32'hA500_0000);
        check("b2b.spacing", 32'(last_hs - h1), 32'd3);
        txn("sh", 0, 1, 32'h0000_3002, 32'h1234_BEEF, 2'b01, 0, 0, 0, 32'h0,
            32'h0, 0, 4'b1100, 32'hBEEF_0000);

        // Loads with extension
        txn("lh", 1, 0, 32'h0000_1002, 32'h0, 2'b01, 0, 0, 0, 32'h8001_1234,
            32'hFFFF_8001, 0, 4'b1100, 32'h0);
        txn("lhu", 1, 0, 32'h0000_1002, 32'h0, 2'b01, 1, 0, 0, 32'h8001_1234,
            32'h0000_8001, 0, 4'b1100, 32'h0);
        txn("lbu", 1, 0, 32'h0000_1001, 32'h0, 2'b00, 1, 0, 0, 32'h0000_7F00,
            32'h0000_007F, 0, 4'b0010, 32'h0);
        txn("lb", 1, 0, 32'h0000_1003, 32'h0, 2'b00, 0, 0, 0, 32'h8000_0000,
            32'hFFFF_FF80, 0, 4'b1000, 32'h0);
        txn("lw", 1, 0, 32'h0000_1004, 32'h0, 2'b10, 0, 0, 0, 32'h1234_5678,
            32'h1234_5678, 0, 4'b1111, 32'h0);

        // Illegal / misaligned -> immediate trap, no memory access
        txn("lw_mis", 1, 0, 32'h0000_1001, 32'h0, 2'b10, 0, 0, 0, 32'h0,
            32'h0, 1, 4'b0, 32'h0);
        txn("sh_mis", 0, 1, 32'h0000_1003, 32'h5555_5555, 2'b01, 0, 0, 0, 32'h0,
            32'h0, 1, 4'b0, 32'h0);
        txn("size11", 1, 0, 32'h0000_1000, 32'h0, 2'b11, 0, 0, 0, 32'h0,
            32'h0, 1, 4'b0, 32'h0);
        txn("ld_and_st", 1, 1, 32'h0000_1000, 32'h0, 2'b10, 0, 0, 0, 32'h0,
            32'h0, 1, 4'b0, 32'h0);
        txn("no_op", 0, 0, 32'h0000_1000, 32'h0, 2'b10, 0, 0, 0, 32'h0,
            32'h0, 1, 4'b0, 32'h0);

        // Slow memory: ready low 3 cycles, rvalid 2 cycles late
        txn("lw_slow", 1, 0, 32'h0000_4008, 32'h0, 2'b10, 0, 3, 2, 32'hCAFE_F00D,
            32'hCAFE_F00D, 0, 4'b1111, 32'h0);

        // Reset while in WAIT: transaction dropped, no response
        check("rstw.ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_load = 1'b1; req_addr = 32'h0000_5000; req_size = 2'b10;
        step();
        req_valid = 1'b0; req_load = 1'b0;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check("rstw.in_wait", 32'(mem_valid), 32'd0);
        rst = 1'b1;
        step();
        check("rstw.ready_in_rst", 32'(req_ready), 32'd0);
        check("rstw.mem_valid", 32'(mem_valid), 32'd0);
        check("rstw.resp_valid", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("rstw.ready_back", 32'(req_ready), 32'd1);
        any_resp = 1'b0;
        for (int k = 0; k < 5; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h7777_7777;
            step();
            if (resp_valid === 1'b1) any_resp = 1'b1;
        end
        mem_rvalid = 1'b0;
        check("rstw.no_resp", 32'(any_resp), 32'd0);
        txn("lb_after_rst", 1, 0, 32'h0000_1000, 32'h0, 2'b00, 0, 0, 0, 32'h0000_00FF,
            32'hFFFF_FFFF, 0, 4'b0001, 32'h0);

        // Memory never ready
        req_valid = 1'b1; req_load = 1'b1; req_addr = 32'h0000_6000; req_size = 2'b10;
        req_unsigned = 1'b0;
        step();
        c0 = cyc;
        req_valid = 1'b0; req_load = 1'b0;
`ifdef LSU_TIMEOUT_EN
        begin
            exp_t e;
            e.rdata  = 32'h0;
            e.trap   = 1'b1;
            e.at_cyc = c0 + 4;
            sb.push_back(e);
        end
        for (int k = 0; k < 4; k++) begin
            check("tmo.mem_valid", 32'(mem_valid), 32'd1);
            step();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        expect_resp("tmo");
        step();
        mem_rvalid = 1'b0;
        check("tmo.late_rvalid", 32'(resp_valid), 32'd0);
        check("tmo.ready", 32'(req_ready), 32'd1);
`else
        memv_cycles = 0;
        any_resp = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (mem_valid === 1'b1) memv_cycles++;
            if (resp_valid === 1'b1) any_resp = 1'b1;
            step();
        end
        check("notmo.start_cycle", 32'(cyc - c0), 32'd100);
        check("notmo.mem_valid_cycles", 32'(memv_cycles), 32'd100);
        check("notmo.no_resp", 32'(any_resp), 32'd0);
        check("notmo.still_req", 32'(mem_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("notmo.recover_valid", 32'(mem_valid), 32'd0);
        check("notmo.recover_ready", 32'(req_ready), 32'd1);
`endif

        check("sb.empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
